// File: rtl/reg_universal_pp.sv
// General-purpose register with a programmable reset pattern and per-cycle
// operations: hold, load, shift left/right, rotate, increment, decrement and
// negate. CO and ZERO are registered together with Q.
module reg_universal_pp #(
    parameter int                WIDTH   = 32,
    parameter logic [WIDTH-1:0]  PATTERN = '0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic [2:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic             SI,
    output logic [WIDTH-1:0] Q,
    output logic             CO,
    output logic             ZERO
);

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHL  = 3'b010,
        OP_SHR  = 3'b011,
        OP_ROL  = 3'b100,
        OP_INC  = 3'b101,
        OP_DEC  = 3'b110,
        OP_NEG  = 3'b111
    } op_e;

    localparam logic [WIDTH:0] ONE_EXT      = {{WIDTH{1'b0}}, 1'b1};
    localparam logic           PATTERN_ZERO = (PATTERN == '0);

    logic [WIDTH-1:0] q_q, q_d;
    logic             co_q, co_d;
    logic             zero_q, zero_d;
    logic [WIDTH:0]   sum_ext;
    op_e              op;

    assign op = op_e'(MODE);

    // Next-state selection; ZERO is derived from the next Q, not the current one.
    always_comb begin
        q_d     = q_q;
        co_d    = co_q;
        sum_ext = '0;
        if (EN) begin
            unique case (op)
                OP_HOLD: begin
                    q_d  = q_q;
                    co_d = co_q;
                end
                OP_LOAD: begin
                    q_d  = D;
                    co_d = 1'b0;
                end
                OP_SHL: begin
                    q_d  = {q_q[WIDTH-2:0], SI};
                    co_d = q_q[WIDTH-1];
                end
                OP_SHR: begin
                    q_d  = {SI, q_q[WIDTH-1:1]};
                    co_d = q_q[0];
                end
                OP_ROL: begin
                    q_d  = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    co_d = q_q[WIDTH-1];
                end
                OP_INC: begin
                    sum_ext = {1'b0, q_q} + ONE_EXT;
                    q_d     = sum_ext[WIDTH-1:0];
                    co_d    = sum_ext[WIDTH];
                end
                OP_DEC: begin
                    q_d  = q_q - {{(WIDTH-1){1'b0}}, 1'b1};
                    co_d = (q_q == '0);
                end
                OP_NEG: begin
                    // Carry out of ~Q + 1 is set only when Q was zero.
                    sum_ext = {1'b0, ~q_q} + ONE_EXT;
                    q_d     = sum_ext[WIDTH-1:0];
                    co_d    = sum_ext[WIDTH];
                end
                default: begin
                    q_d  = q_q;
                    co_d = co_q;
                end
            endcase
        end
        zero_d = (q_d == '0);
    end

    // State registers with synchronous reset to the programmed pattern.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            q_q    <= PATTERN;
            co_q   <= 1'b0;
            zero_q <= PATTERN_ZERO;
        end else begin
            q_q    <= q_d;
            co_q   <= co_d;
            zero_q <= zero_d;
        end
    end

    assign Q    = q_q;
    assign CO   = co_q;
    assign ZERO = zero_q;

endmodule
